// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned PC_STEP    = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop.
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= din;
                wr_ptr_q      <= AW'(wr_ptr_q + 1'b1);
            end
            if (do_pop) begin
                rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests,
// buffers returned words and hands {instr, pc} to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     BUF_DEPTH       = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            PCsrc,
    input  logic [XLEN-1:0] PCTarget
);

    localparam int unsigned BW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(BUF_DEPTH + MAX_OUTSTANDING + 1) + 1;

    logic [XLEN-1:0] pc_q;
    logic            req_en_q;
    logic [OW-1:0]   drop_cnt_q;
    logic [OW-1:0]   drop_d;
    fetch_state_e    state_q;
    fetch_entry_t    hold_q;

    fetch_entry_t    buf_din;
    fetch_entry_t    buf_head;
    logic [BW-1:0]   buf_count;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    pcq_din;
    fetch_entry_t    pcq_head;
    logic [OW-1:0]   outstanding;
    logic            pcq_full;
    logic            pcq_empty;

    logic [SW-1:0]   in_use;
    logic            req_fire;
    logic            rsp_keep;
    logic            instr_fire;
    logic            unused_ok;

    // Slots already claimed: kept in-flight responses plus buffered words.
    assign in_use         = SW'(outstanding) - SW'(drop_cnt_q) + SW'(buf_count);
    assign imem_req_valid = req_en_q && (in_use < SW'(BUF_DEPTH)) && !pcq_full && !PCsrc;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (state_q == S_RUN) && !PCsrc;
    assign instr_fire     = instr_valid && instr_ready;

    assign buf_din = '{pc: pcq_head.pc, instr: imem_rsp_data};
    assign pcq_din = '{pc: pc_q, instr: '0};

    assign instr_valid = !buf_empty;
    assign instr       = buf_empty ? hold_q.instr : buf_head.instr;
    assign instr_pc    = buf_empty ? hold_q.pc    : buf_head.pc;

    assign unused_ok = ^{buf_full, pcq_empty, pcq_head.instr, PCTarget[1:0]};

    instr_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep),
        .din   (buf_din),
        .pop   (instr_fire),
        .flush (PCsrc),
        .dout  (buf_head),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    // In-flight PC queue; its occupancy is the outstanding-request count.
    instr_fifo #(.DEPTH(MAX_OUTSTANDING)) u_pcq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .din   (pcq_din),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .dout  (pcq_head),
        .count (outstanding),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    // A redirect orphans every response still pending after this cycle.
    always_comb begin
        drop_d = drop_cnt_q;
        if (PCsrc) begin
            drop_d = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_d = drop_cnt_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_en_q   <= 1'b0;
            drop_cnt_q <= '0;
            state_q    <= S_RUN;
            hold_q     <= '0;
        end else begin
            req_en_q   <= 1'b1;
            drop_cnt_q <= drop_d;
            state_q    <= (drop_d != '0) ? S_DRAIN : S_RUN;
            if (PCsrc) begin
                pc_q <= {PCTarget[XLEN-1:2], 2'b00};
            end else if (req_fire) begin
                pc_q <= pc_q + XLEN'(PC_STEP);
            end
            if (!buf_empty) begin
                hold_q <= buf_head;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order latency-configurable imem model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          PERIOD   = 10;
    localparam int          HALF     = 5;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct { int due; logic [31:0] data; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        PCsrc = 1'b0;
    logic [31:0] PCTarget = '0;

    int   lat = 1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;
    bit   got_first = 1'b0;
    time  first_acc_t = 0;
    rsp_t        pend[$];
    logic [31:0] acc_q[$];
    exp_t        exp_q[$];

    always #(HALF) clk = ~clk;

    fetch_unit #(
        .XLEN(32), .RESET_PC(RESET_PC), .BUF_DEPTH(2), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .PCsrc(PCsrc), .PCTarget(PCTarget)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Memory word at an address is its bitwise complement.
    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, instr: ~pc});
    endtask

    task automatic check_acc(input int idx, input logic [31:0] want);
        check("req_addr", (idx < acc_q.size()) ? acc_q[idx] : 32'hDEAD_BEEF, want);
    endtask

    // Open the request port until exactly n requests have been accepted.
    task automatic run_acc(input int n);
        int k = 0;
        imem_req_ready = 1'b1;
        while (acc_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        imem_req_ready = 1'b0;
        check("accept_count", 32'(acc_q.size()), 32'(n));
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Memory model: record accepts at the edge, return in order after lat cycles.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                if (!got_first) begin
                    got_first   = 1'b1;
                    first_acc_t = $time;
                end
                pend.push_back('{due: cyc + lat, data: ~imem_req_addr});
                acc_q.push_back(imem_req_addr);
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n && pend.size() > 0 && pend[0].due < cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Monitor: every accepted instruction is compared against the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        if (rst_n && mon_en && instr_valid && instr_ready && !PCsrc) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc %h, expected no output", instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;

        // Reset values
        #3;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        repeat (3) @(negedge clk);

        // Sequential fetch, latency 1, decode always ready
        for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
        rst_n = 1'b1;
        k = 0;
        seen = 1'b0;
        while ((acc_q.size() < 8 || !seen) && k < 300) begin
            @(negedge clk);
            k++;
            if (acc_q.size() >= 8) imem_req_ready = 1'b0;
            if (!seen && instr_valid) begin
                seen = 1'b1;
                check("first_valid_latency", 32'(($time - first_acc_t - HALF) / PERIOD), 32'd2);
            end
        end
        imem_req_ready = 1'b0;
        check("first_valid_seen", 32'(seen), 32'd1);
        check("accept_count", 32'(acc_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check_acc(i, 32'(i * 4));
        wait_drain();

        // Decode stalled: only BUF_DEPTH requests may be accepted
        acc_q.delete();
        for (int i = 0; i < 4; i++) expect_pc(32'h20 + 32'(i * 4));
        instr_ready = 1'b0;
        imem_req_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("stall_accepts", 32'(acc_q.size()), 32'd2);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        instr_ready = 1'b1;
        run_acc(4);
        for (int i = 0; i < 4; i++) check_acc(i, 32'h20 + 32'(i * 4));
        wait_drain();

        // Redirect with two latency-3 requests in flight
        acc_q.delete();
        lat = 3;
        expect_pc(32'h100);
        expect_pc(32'h104);
        run_acc(2);
        PCsrc = 1'b1;
        PCTarget = 32'h100;
        @(negedge clk);
        PCsrc = 1'b0;
        run_acc(4);
        check_acc(0, 32'h30);
        check_acc(1, 32'h34);
        check_acc(2, 32'h100);
        check_acc(3, 32'h104);
        wait_drain();

        // Back-to-back redirects, last one unaligned
        acc_q.delete();
        lat = 2;
        expect_pc(32'h100);
        expect_pc(32'h104);
        PCsrc = 1'b1;
        PCTarget = 32'h200;
        imem_req_ready = 1'b1;
        @(negedge clk);
        PCTarget = 32'h103;
        @(negedge clk);
        PCsrc = 1'b0;
        run_acc(2);
        check_acc(0, 32'h100);
        check_acc(1, 32'h104);
        wait_drain();

        // PC wrap at the top of the address space
        acc_q.delete();
        lat = 1;
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        PCsrc = 1'b1;
        PCTarget = 32'hFFFF_FFFC;
        @(negedge clk);
        PCsrc = 1'b0;
        run_acc(2);
        check_acc(0, 32'hFFFF_FFFC);
        check_acc(1, 32'h0000_0000);
        wait_drain();

        // Asynchronous reset in the middle of a burst
        mon_en = 1'b0;
        lat = 2;
        acc_q.delete();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check("arst_instr_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", instr, 32'd0);
        check("arst_instr_pc", instr_pc, 32'd0);
        @(negedge clk);
        @(negedge clk);
        acc_q.delete();
        exp_q.delete();
        mon_en = 1'b1;
        expect_pc(RESET_PC);
        expect_pc(RESET_PC + 32'd4);
        rst_n = 1'b1;
        run_acc(2);
        check_acc(0, RESET_PC);
        check_acc(1, RESET_PC + 32'd4);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end: owns the PC, issues in-order requests to instruction memory, and buffers returned words.
- Presents {instr, pc} to the decode/control stage over a valid/ready handshake.
- Consumes the control path's PCsrc/PCTarget redirect, flushing buffered and in-flight fetches.
- Sits between instruction memory and the control decoder, as the producer of the instruction word that control decodes.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- BUF_DEPTH, 2, instruction buffer entries; must be a power of 2, ≥2.
- MAX_OUTSTANDING, 2, maximum imem requests in flight, ≤ BUF_DEPTH.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_rsp_data  in  XLEN  instruction word.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr_ready  in  1  decode accepts instruction.
- instr  out  XLEN  instruction word.
- instr_pc  out  XLEN  PC of instr.
- PCsrc  in  1  redirect request (branch taken).
- PCTarget  in  XLEN  redirect target; bits[1:0] ignored, treated as 00.

Behaviour:
- Reset (async assert, sync release):
  - pc_q = RESET_PC.
  - Buffer empty; outstanding = 0; drop_cnt = 0; state = S_RUN.
  - imem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
  - Reset mid-operation discards everything, including in-flight responses; the memory must also be reset.
- Credit rule:
  - imem_req_valid = (outstanding − drop_cnt + count) < BUF_DEPTH, and outstanding < MAX_OUTSTANDING, and !PCsrc.
  - This guarantees every kept response has a buffer slot; no response backpressure exists.
- Request:
  - imem_req_addr = pc_q.
  - On req_valid & req_ready: pc_q += 4, wrapping 32'hFFFF_FFFC → 0. The PC is pushed into an in-flight PC queue (depth MAX_OUTSTANDING).
- Response:
  - On rsp_valid: outstanding −1 and the in-flight PC queue is popped.
  - If drop_cnt ≠ 0: the word is discarded and drop_cnt −1.
  - Otherwise {pc, data} is pushed into the buffer.
  - Request accept and response in the same cycle: outstanding unchanged.
- Output:
  - instr_valid = buffer non-empty; instr/instr_pc = buffer head (registered storage, no combinational path from imem_rsp).
  - Pop on instr_valid & instr_ready.
  - Zero-latency bypass is not required. Minimum latency from request accept to instr_valid = mem latency + 1.
- Redirect (PCsrc = 1 sampled at clk edge):
  - pc_q ← {PCTarget[XLEN−1:2], 2'b00}.
  - Buffer flushed; a simultaneous pop is void.
  - drop_cnt ← outstanding after this cycle's response and accept, i.e. all still-pending responses.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - First request to the target is issued the next cycle.
- FSM:
  - S_RUN: drop_cnt = 0.
  - S_DRAIN: drop_cnt > 0. Requests to the new path may issue. Returns to S_RUN when drop_cnt reaches 0.
  - A redirect in S_DRAIN reloads drop_cnt with the total outstanding.
- Buffer full: impossible to overflow by the credit rule; an assertion flags a push when full.
- Buffer empty: instr_valid = 0 and instr holds its last value.
- Back-to-back redirects: each is honoured; the last one wins.

Decomposition:
- fetch_pkg:
  - localparam PC_STEP = 4.
  - typedef fetch_entry_t = struct {pc, instr}.
  - FSM enum fetch_state_e {S_RUN, S_DRAIN}.
- Sub-module instr_fifo:
  - Parameterised sync FIFO of fetch_entry_t with push, pop, flush, count, full, empty.
  - Flush has priority over push and pop.
  - Reused for the in-flight PC queue.

Test Plan:
- Reset release, mem latency 1, instr_ready = 1 → addrs 0x0, 0x4, 0x8… issued. instr_valid first high 2 cycles after the first accept; instr_pc sequence matches.
- instr_ready = 0 for 10 cycles → exactly BUF_DEPTH requests accepted, req_valid then 0. Releasing ready resumes in order with no loss or duplicate.
- Mem latency 3 with 2 outstanding; PCsrc = 1, PCTarget = 0x100 → both old responses dropped; next instr_pc = 0x100, then 0x104.
- PCTarget = 0x103 → first request addr 0x100.
- pc_q = 0xFFFF_FFFC → next request addr 0x0000_0000.
- Async rst_n low mid-burst, off-edge → outputs 0 immediately; after release, first addr = RESET_PC.
